// File: rtl/cache_line_state_if.sv
// cache_line_state_if
//   Bundles the line-operation port, the per-set read port, the flush
//   control and the writeback handshake of cache_line_state.
//
//   Parameters
//     s_index     set index width  (num_sets = 2**s_index)
//     w_index     way index width  (num_ways = 2**w_index)
//
//   Signals
//     op          line operation (000 idle, 001 fill, 010 mark dirty,
//                 011 clean, 100 invalidate, others idle)
//     set_sel     set addressed by op and by the read port
//     way_sel     way addressed by op
//     valid_out   valid bits of every way in set_sel
//     dirty_out   dirty bits of every way in set_sel
//     flush_req   start a flush (only looked at while idle)
//     flush_busy  flush engine active
//     flush_done  one-cycle pulse when a flush completes
//     wb_valid    line at wb_set/wb_way is offered for writeback
//     wb_set      set of the offered line
//     wb_way      way of the offered line
//     wb_ready    writeback path accepts the offered line
//
//   Modports
//     master      cache controller / writeback side
//     slave       the line-state array itself
interface cache_line_state_if #(
  parameter int s_index = 4,
  parameter int w_index = 2
);

  localparam int num_ways = 2 ** w_index;

  logic [2:0]          op;
  logic [s_index-1:0]  set_sel;
  logic [w_index-1:0]  way_sel;
  logic [num_ways-1:0] valid_out;
  logic [num_ways-1:0] dirty_out;

  logic                flush_req;
  logic                flush_busy;
  logic                flush_done;

  logic                wb_valid;
  logic [s_index-1:0]  wb_set;
  logic [w_index-1:0]  wb_way;
  logic                wb_ready;

  modport master (
    output op, set_sel, way_sel, flush_req, wb_ready,
    input  valid_out, dirty_out, flush_busy, flush_done,
           wb_valid, wb_set, wb_way
  );

  modport slave (
    input  op, set_sel, way_sel, flush_req, wb_ready,
    output valid_out, dirty_out, flush_busy, flush_done,
           wb_valid, wb_set, wb_way
  );

endinterface

// File: rtl/cache_line_state.sv
// cache_line_state
//   Valid/dirty state for every (set, way) of a set-associative cache,
//   plus a flush engine that walks all lines and offers each valid-dirty
//   one to the writeback path over a valid/ready handshake.
//
//   Ports
//     clk    clock
//     rst    synchronous, active-high reset; clears all state and aborts
//            any flush in progress without a flush_done pulse
//     bus    cache_line_state_if.slave: op/set_sel/way_sel line updates,
//            valid_out/dirty_out combinational read of set_sel,
//            flush_req/flush_busy/flush_done flush control,
//            wb_valid/wb_set/wb_way/wb_ready writeback handshake
//
//   Build option
//     CACHE_LINE_STATE_FLUSH_INV_EN
//       defined:   every writeback transfer clears V and D, and the DONE
//                  state invalidates the whole array, so the cache is
//                  empty after a flush.
//       undefined: a flush only cleans lines; valid lines stay valid.
module cache_line_state #(
  parameter int s_index = 4,
  parameter int w_index = 2
) (
  input logic               clk,
  input logic               rst,
  cache_line_state_if.slave bus
);

  localparam int num_sets = 2 ** s_index;
  localparam int num_ways = 2 ** w_index;
  localparam int idx_w    = s_index + w_index;

  localparam logic [idx_w-1:0] LAST_IDX = '1;
  localparam logic [idx_w-1:0] IDX_ONE  = idx_w'(1);

  localparam logic [2:0] OP_FILL  = 3'b001;
  localparam logic [2:0] OP_DIRTY = 3'b010;
  localparam logic [2:0] OP_CLEAN = 3'b011;
  localparam logic [2:0] OP_INVAL = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WB,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [idx_w-1:0] idx_q, idx_d;

  logic [num_sets-1:0][num_ways-1:0] valid_q;
  logic [num_sets-1:0][num_ways-1:0] dirty_q;

  logic [s_index-1:0] cur_set;
  logic [w_index-1:0] cur_way;
  logic               cur_vd;
  logic               wb_xfer;

  // The scan index is laid out {set, way}, so the way advances fastest.
  assign cur_set = idx_q[idx_w-1:w_index];
  assign cur_way = idx_q[w_index-1:0];
  assign cur_vd  = valid_q[cur_set][cur_way] & dirty_q[cur_set][cur_way];
  assign wb_xfer = (state_q == WB) && bus.wb_ready;

  // Flush state and scan index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic and status outputs of the flush engine.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    bus.flush_busy = 1'b0;
    bus.flush_done = 1'b0;
    bus.wb_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end

      SCAN: begin
        bus.flush_busy = 1'b1;
        // A dirty line parks the index so WB can offer it; otherwise
        // the scan moves on or finishes after the final line.
        if (cur_vd) begin
          state_d = WB;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end

      WB: begin
        bus.flush_busy = 1'b1;
        bus.wb_valid   = 1'b1;
        // The index is frozen until the writeback path takes the line,
        // which keeps wb_set/wb_way stable under backpressure.
        if (bus.wb_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            state_d = SCAN;
            idx_d   = idx_q + IDX_ONE;
          end
        end
      end

      DONE: begin
        bus.flush_busy = 1'b1;
        bus.flush_done = 1'b1;
        state_d        = IDLE;
        idx_d          = '0;
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign bus.wb_set = cur_set;
  assign bus.wb_way = cur_way;

  // Reads are straight from the flops, so an update becomes visible
  // only in the cycle after the edge that wrote it.
  assign bus.valid_out = valid_q[bus.set_sel];
  assign bus.dirty_out = dirty_q[bus.set_sel];

  // Line state array. Controller ops are honoured only while idle,
  // which includes the cycle that launches a flush; the flush engine
  // owns the array for the rest of the flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (state_q == IDLE) begin
        case (bus.op)
          OP_FILL: begin
            valid_q[bus.set_sel][bus.way_sel] <= 1'b1;
            dirty_q[bus.set_sel][bus.way_sel] <= 1'b0;
          end
          OP_DIRTY: begin
            // Only a resident line can become dirty.
            if (valid_q[bus.set_sel][bus.way_sel]) begin
              dirty_q[bus.set_sel][bus.way_sel] <= 1'b1;
            end
          end
          OP_CLEAN: begin
            dirty_q[bus.set_sel][bus.way_sel] <= 1'b0;
          end
          OP_INVAL: begin
            valid_q[bus.set_sel][bus.way_sel] <= 1'b0;
            dirty_q[bus.set_sel][bus.way_sel] <= 1'b0;
          end
          default: begin
          end
        endcase
      end

      if (wb_xfer) begin
        dirty_q[cur_set][cur_way] <= 1'b0;
`ifdef CACHE_LINE_STATE_FLUSH_INV_EN
        valid_q[cur_set][cur_way] <= 1'b0;
`endif
      end

`ifdef CACHE_LINE_STATE_FLUSH_INV_EN
      // Leave the cache completely empty once the walk has finished.
      if (state_q == DONE) begin
        valid_q <= '0;
        dirty_q <= '0;
      end
`endif
    end
  end

endmodule
